// File: rtl/present_pkg.sv
// -----------------------------------------------------------------------------
// present_pkg
//   Shared definitions for the PRESENT round engine:
//     RC_W          width of the round counter (limits ROUNDS to 31)
//     SBOX          4-bit PRESENT substitution table
//     fsm_state_e   engine FSM states (IDLE / RUN / DONE)
//     sbox4         single-nibble substitution
//     sbox_layer64  substitution applied to all sixteen nibbles of a block
//     p_layer64     PRESENT bit permutation (bit i -> 16*i mod 63, 63 -> 63)
// -----------------------------------------------------------------------------
package present_pkg;

  localparam int RC_W = 5;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [63:0] sbox_layer64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[6'(4 * n) +: 4] = sbox4(x[6'(4 * n) +: 4]);
    end
    return y;
  endfunction

  // Pure wiring: each source bit lands at 16*i mod 63; the MSB is a fixed point.
  function automatic logic [63:0] p_layer64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[6'((16 * i) % 63)] = x[6'(i)];
    end
    y[63] = x[63];
    return y;
  endfunction

endpackage

// File: rtl/present_key_update.sv
// -----------------------------------------------------------------------------
// present_key_update
//   Combinational PRESENT key-schedule step: derives K(i+1) register contents
//   from the current key register and the round counter of the round that is
//   consuming the current key.
//   Parameters:
//     KEY_W   80 or 128
//   Ports:
//     key_i   [KEY_W-1:0]  current key register
//     rc_i    [RC_W-1:0]   round counter of the round being executed
//     key_o   [KEY_W-1:0]  updated key register
// -----------------------------------------------------------------------------
module present_key_update
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] key_i,
  input  logic [RC_W-1:0]  rc_i,
  output logic [KEY_W-1:0] key_o
);

  // Rotate left by 61: the low KEY_W-61 bits move to the top.
  logic [KEY_W-1:0] rot;
  assign rot = {key_i[KEY_W-62:0], key_i[KEY_W-1:KEY_W-61]};

  generate
    if (KEY_W == 80) begin : g_k80
      always_comb begin
        // NOTE: key_o takes a full default first so that the partial
        // overrides below never leave a bit unassigned (no latch).
        key_o         = rot;
        key_o[79:76]  = sbox4(rot[79:76]);
        key_o[19:15]  = rot[19:15] ^ rc_i;
      end
    end else if (KEY_W == 128) begin : g_k128
      always_comb begin
        key_o           = rot;
        key_o[127:124]  = sbox4(rot[127:124]);
        key_o[123:120]  = sbox4(rot[123:120]);
        key_o[66:62]    = rot[66:62] ^ rc_i;
      end
    end else begin : g_bad_key_w
      $error("present_key_update: KEY_W must be 80 or 128");
      assign key_o = rot;
    end
  endgenerate

endmodule

// File: rtl/present_round_engine.sv
// -----------------------------------------------------------------------------
// present_round_engine
//   Iterative PRESENT encryption core, one S/P round per clock, with the round
//   key computed on the fly for 80- or 128-bit keys.
//   Parameters:
//     KEY_W    80 or 128
//     ROUNDS   number of S/P rounds, 1..31
//   Ports:
//     clk_i    clock, rising edge
//     rst_i    synchronous active-high reset
//     valid_i  plaintext/key valid          ready_o  engine can accept a block
//     data_i   [63:0] plaintext             key_i    [KEY_W-1:0] cipher key
//     valid_o  ciphertext valid             ready_i  downstream accepts result
//     data_o   [63:0] ciphertext (0 unless valid_o)
//     busy_o   high while a block is in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module present_round_engine
  import present_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [63:0]      data_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [63:0]      data_o,
  output logic             busy_o
);

  generate
    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
      $error("present_round_engine: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present_round_engine: ROUNDS must be in 1..31");
    end
  endgenerate

  localparam logic [RC_W-1:0] LAST_RC = RC_W'(ROUNDS);

  fsm_state_e       fsm_q,   fsm_d;
  logic [63:0]      state_q, state_d;
  logic [KEY_W-1:0] key_q,   key_d;
  logic [RC_W-1:0]  rc_q,    rc_d;

  logic [63:0]      round_key;
  logic [63:0]      round_out;
  logic [KEY_W-1:0] key_next;

  // The round key is always the top 64 bits of the key register.
  assign round_key = key_q[KEY_W-1 -: 64];
  assign round_out = p_layer64(sbox_layer64(state_q ^ round_key));

  present_key_update #(
    .KEY_W (KEY_W)
  ) u_key_update (
    .key_i (key_q),
    .rc_i  (rc_q),
    .key_o (key_next)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;

    unique case (fsm_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d = data_i;
          key_d   = key_i;
          rc_d    = RC_W'(1);
          fsm_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        state_d = round_out;
        key_d   = key_next;
        rc_d    = rc_q + RC_W'(1);
        if (rc_q == LAST_RC) begin
          fsm_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // State and key are frozen here, which keeps data_o stable under
        // backpressure.
        if (ready_i) begin
          fsm_d = ST_IDLE;
        end
      end

      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the values
    // computed from the pre-edge state, independent of statement order.
    if (rst_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: functions of registered state only
  // ---------------------------------------------------------------------------
  assign ready_o = (fsm_q == ST_IDLE);
  assign valid_o = (fsm_q == ST_DONE);
  assign busy_o  = (fsm_q != ST_IDLE);
  // Final whitening with K(ROUNDS+1); intermediate rounds are never exposed.
  assign data_o  = (fsm_q == ST_DONE) ? (state_q ^ round_key) : 64'd0;

endmodule

// File: tb/tb_present_round_engine.sv
// -----------------------------------------------------------------------------
// tb_present_round_engine
//   Three engines share a clock and reset:
//     d0: KEY_W=80,  ROUNDS=31
//     d1: KEY_W=128, ROUNDS=31
//     d2: KEY_W=80,  ROUNDS=1
//   A transaction-level reference (full PRESENT encryption per accepted
//   block plus a rounds-remaining timer) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_present_round_engine;

  localparam int KW [3] = '{80, 128, 80};
  localparam int RN [3] = '{31, 31, 1};

  localparam logic [3:0] TB_SBOX [16] = '{
    4'd12, 4'd5, 4'd6, 4'd11, 4'd9, 4'd0, 4'd10, 4'd13,
    4'd3, 4'd14, 4'd15, 4'd8, 4'd4, 4'd7, 4'd1, 4'd2
  };

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        vi   [3];
  logic        rdy  [3];
  logic [63:0] di   [3];
  logic [127:0] ki  [3];
  logic        vo   [3];
  logic        ro   [3];
  logic        bo   [3];
  logic [63:0] dout [3];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 clk_i = ~clk_i;

  present_round_engine #(.KEY_W(80), .ROUNDS(31)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(vi[0]), .ready_o(ro[0]),
    .data_i(di[0]), .key_i(ki[0][79:0]), .valid_o(vo[0]), .ready_i(rdy[0]),
    .data_o(dout[0]), .busy_o(bo[0]));

  present_round_engine #(.KEY_W(128), .ROUNDS(31)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(vi[1]), .ready_o(ro[1]),
    .data_i(di[1]), .key_i(ki[1]), .valid_o(vo[1]), .ready_i(rdy[1]),
    .data_o(dout[1]), .busy_o(bo[1]));

  present_round_engine #(.KEY_W(80), .ROUNDS(1)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(vi[2]), .ready_o(ro[2]),
    .data_i(di[2]), .key_i(ki[2][79:0]), .valid_o(vo[2]), .ready_i(rdy[2]),
    .data_o(dout[2]), .busy_o(bo[2]));

  // ---------------------------------------------------------------------------
  // Reference cipher
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] top64(logic [127:0] k, int kw);
    return (kw == 80) ? k[79:16] : k[127:64];
  endfunction

  function automatic logic [127:0] next_key(logic [127:0] k, int kw, int r);
    logic [79:0]  k80;
    logic [127:0] k128;
    logic [4:0]   rc;
    rc = r[4:0];
    if (kw == 80) begin
      k80 = k[79:0];
      k80 = (k80 << 61) | (k80 >> 19);
      k80[79:76] = TB_SBOX[k80[79:76]];
      k80[19:15] = k80[19:15] ^ rc;
      return {48'd0, k80};
    end
    k128 = (k << 61) | (k >> 67);
    k128[127:124] = TB_SBOX[k128[127:124]];
    k128[123:120] = TB_SBOX[k128[123:120]];
    k128[66:62]   = k128[66:62] ^ rc;
    return k128;
  endfunction

  function automatic logic [63:0] ref_encrypt(logic [63:0] pt, logic [127:0] key,
                                              int kw, int rounds);
    logic [63:0]  s, t;
    logic [127:0] k;
    s = pt;
    k = (kw == 80) ? {48'd0, key[79:0]} : key;
    for (int r = 1; r <= rounds; r++) begin
      s = s ^ top64(k, kw);
      for (int n = 0; n < 16; n++) s[4*n +: 4] = TB_SBOX[s[4*n +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
      k = next_key(k, kw, r);
    end
    return s ^ top64(k, kw);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference timing model: one block in flight per engine
  // ---------------------------------------------------------------------------
  bit          m_busy [3];
  int          m_left [3];
  bit [63:0]   m_ct   [3];
  bit          m_acc  [3];

  always @(posedge clk_i) begin
    for (int i = 0; i < 3; i++) begin
      m_acc[i] <= 1'b0;
      if (rst_i) begin
        m_busy[i] <= 1'b0;
        m_left[i] <= 0;
      end else if (!m_busy[i]) begin
        if (vi[i]) begin
          m_busy[i] <= 1'b1;
          m_left[i] <= RN[i];
          m_ct[i]   <= ref_encrypt(di[i], ki[i], KW[i], RN[i]);
          m_acc[i]  <= 1'b1;
        end
      end else if (m_left[i] != 0) begin
        m_left[i] <= m_left[i] - 1;
      end else if (rdy[i]) begin
        m_busy[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("d%0d ready_o", i), 64'(ro[i]), 64'(!m_busy[i]));
        check($sformatf("d%0d busy_o", i),  64'(bo[i]), 64'(m_busy[i]));
        check($sformatf("d%0d valid_o", i), 64'(vo[i]),
              64'(m_busy[i] && m_left[i] == 0));
        check($sformatf("d%0d data_o", i), dout[i],
              (m_busy[i] && m_left[i] == 0) ? m_ct[i] : 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input int idx, input logic [63:0] pt, input logic [127:0] k);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!ro[idx] && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!ro[idx]) check($sformatf("d%0d send timeout", idx), 64'(ro[idx]), 64'd1);
    di[idx] = pt;
    ki[idx] = k;
    vi[idx] = 1'b1;
    @(negedge clk_i);
    vi[idx] = 1'b0;
  endtask

  // Returns the number of edges after acceptance until valid_o is seen.
  task automatic wait_valid(input int idx, input bit pulse, output int lat);
    lat = 0;
    while (!vo[idx] && lat < 100) begin
      if (pulse) begin
        vi[idx] = 1'($urandom_range(0, 1));
        di[idx] = {$urandom, $urandom};
      end
      @(negedge clk_i);
      lat++;
    end
    vi[idx] = 1'b0;
    if (!vo[idx]) check($sformatf("d%0d valid timeout", idx), 64'(vo[idx]), 64'd1);
  endtask

  task automatic run_kat(input int idx, input logic [63:0] pt, input logic [127:0] k,
                         input logic [63:0] exp, input string name);
    int lat;
    send(idx, pt, k);
    wait_valid(idx, 1'b0, lat);
    check({name, " latency"}, 64'(lat), 64'(RN[idx]));
    check({name, " data"}, dout[idx], exp);
    @(negedge clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          lat;
    logic [63:0] held;
    int          last_rise [3];
    bit          prev_vo   [3];
    int          cyc;

    for (int i = 0; i < 3; i++) begin
      vi[i] = 1'b0; rdy[i] = 1'b1; di[i] = '0; ki[i] = '0;
    end

    // Reset
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("reset ready_o", 64'(ro[0]), 64'd1);
    check("reset valid_o", 64'(vo[0]), 64'd0);
    check("reset busy_o",  64'(bo[0]), 64'd0);
    check("reset data_o",  dout[0],    64'd0);
    rst_i  = 1'b0;
    cmp_en = 1'b1;

    // Pin the reference cipher to published vectors
    check("model80 0/0", ref_encrypt(64'd0, 128'd0, 80, 31), 64'h5579C1387B228445);
    check("model80 F/F", ref_encrypt('1, {48'd0, {80{1'b1}}}, 80, 31), 64'h3333DCD3213210D2);
    check("model80 0/F", ref_encrypt(64'd0, {48'd0, {80{1'b1}}}, 80, 31), 64'hE72C46C0F5945049);
    check("model128 0/0", ref_encrypt(64'd0, 128'd0, 128, 31), 64'h96DB702A2E6900AF);

    // Known-answer blocks
    run_kat(0, 64'd0, 128'd0, 64'h5579C1387B228445, "kat80 0/0");
    run_kat(0, '1, {48'd0, {80{1'b1}}}, 64'h3333DCD3213210D2, "kat80 F/F");
    run_kat(0, 64'd0, {48'd0, {80{1'b1}}}, 64'hE72C46C0F5945049, "kat80 0/F");
    run_kat(1, 64'd0, 128'd0, 64'h96DB702A2E6900AF, "kat128 0/0");

    // Backpressure, with valid_i pulses during RUN and DONE
    rdy[0] = 1'b0;
    send(0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    wait_valid(0, 1'b1, lat);
    check("bp latency", 64'(lat), 64'd31);
    held = dout[0];
    for (int c = 0; c < 10; c++) begin
      vi[0] = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      check("bp data held", dout[0], held);
      check("bp valid held", 64'(vo[0]), 64'd1);
      check("bp ready low", 64'(ro[0]), 64'd0);
    end
    vi[0]  = 1'b0;
    rdy[0] = 1'b1;
    @(negedge clk_i);
    check("bp release ready_o", 64'(ro[0]), 64'd1);
    check("bp release valid_o", 64'(vo[0]), 64'd0);

    // Reset at round 15
    send(0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    repeat (14) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst ready_o", 64'(ro[0]), 64'd1);
    check("midrst valid_o", 64'(vo[0]), 64'd0);
    check("midrst data_o",  dout[0],    64'd0);
    run_kat(0, 64'd0, 128'd0, 64'h5579C1387B228445, "after midrst");

    // Back-to-back: valid_i held high, ready_i high
    for (int i = 0; i < 3; i++) begin
      last_rise[i] = -1; prev_vo[i] = 1'b0;
      di[i] = {$urandom, $urandom};
      ki[i] = {$urandom, $urandom, $urandom, $urandom};
      vi[i] = 1'b1; rdy[i] = 1'b1;
    end
    for (cyc = 0; cyc < 240; cyc++) begin
      @(negedge clk_i);
      for (int i = 0; i < 3; i++) begin
        if (m_acc[i]) begin
          di[i] = {$urandom, $urandom};
          ki[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (vo[i] && !prev_vo[i]) begin
          if (last_rise[i] >= 0)
            check($sformatf("d%0d b2b period", i), 64'(cyc - last_rise[i]), 64'(RN[i] + 2));
          last_rise[i] = cyc;
        end
        prev_vo[i] = vo[i];
      end
    end
    for (int i = 0; i < 3; i++) vi[i] = 1'b0;
    repeat (40) @(negedge clk_i);

    // Randomized traffic with occasional resets
    repeat (3000) begin
      @(negedge clk_i);
      rst_i = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 3; i++) begin
        vi[i]  = ($urandom_range(0, 2) == 0);
        rdy[i] = 1'($urandom_range(0, 1));
        di[i]  = {$urandom, $urandom};
        ki[i]  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vi[i] = 1'b0; rdy[i] = 1'b1;
    end
    repeat (40) @(negedge clk_i);
    for (int i = 0; i < 3; i++)
      check($sformatf("d%0d drained idle", i), 64'(ro[i]), 64'd1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
